// File: rtl/pair_operand_stage_if.sv
// PHV in / operand-pair out handshake bundle for pair_operand_stage.
// master = upstream feeder + atom side, slave = the operand stage itself.
interface pair_operand_stage_if #(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_W    = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_FIELDS*FIELD_W-1:0] in_phv;
  logic                          out_valid;
  logic                          out_ready;
  logic [FIELD_W-1:0]            out_pkt_1;
  logic [FIELD_W-1:0]            out_pkt_2;
  logic [NUM_FIELDS*FIELD_W-1:0] out_phv;

  modport master (
    output in_valid, in_phv, out_ready,
    input  in_ready, out_valid, out_pkt_1, out_pkt_2, out_phv
  );

  modport slave (
    input  in_valid, in_phv, out_ready,
    output in_ready, out_valid, out_pkt_1, out_pkt_2, out_phv
  );
endinterface

// File: rtl/pair_operand_stage.sv
// Extracts two indexed PHV fields into a 2-entry FIFO feeding the stateful ALU atom; PAIR_OPERAND_PERF_EN adds perf counters.
// Latency: one edge from accept to head when empty; otherwise behind older entries.
// Backpressure: in_ready decodes registered occupancy only (no path from out_ready).
module pair_operand_stage #(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_W    = 32,
  parameter int IDX_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  pair_operand_stage_if.slave bus,
  input  logic               cfg_wr_en,
  input  logic [IDX_W-1:0]   cfg_idx_1,
  input  logic [IDX_W-1:0]   cfg_idx_2,
  output logic               cfg_err
`ifdef PAIR_OPERAND_PERF_EN
  ,
  output logic [31:0]        perf_accepted,
  output logic [31:0]        perf_stalled
`endif
);

  localparam int PHV_W = NUM_FIELDS * FIELD_W;

  logic [1:0]         occ_q, occ_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   idx_1_q, idx_1_d;
  logic [IDX_W-1:0]   idx_2_q, idx_2_d;
  logic               cfg_err_q, cfg_err_d;
  logic [PHV_W-1:0]   phv_q [0:1];
  logic [PHV_W-1:0]   phv_d [0:1];
  logic [FIELD_W-1:0] p1_q  [0:1];
  logic [FIELD_W-1:0] p1_d  [0:1];
  logic [FIELD_W-1:0] p2_q  [0:1];
  logic [FIELD_W-1:0] p2_d  [0:1];

  logic               in_ready;
  logic               out_valid;
  logic               push;
  logic               pop;
  logic               bad_1;
  logic               bad_2;
  logic               head_sel;
  logic [FIELD_W-1:0] ext_1;
  logic [FIELD_W-1:0] ext_2;

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  assign bad_1 = ({1'b0, idx_1_q} >= (IDX_W+1)'(NUM_FIELDS));
  assign bad_2 = ({1'b0, idx_2_q} >= (IDX_W+1)'(NUM_FIELDS));

  // Out-of-range indices match no field and therefore extract zero.
  always_comb begin
    ext_1 = '0;
    ext_2 = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (idx_1_q == IDX_W'(i)) ext_1 = bus.in_phv[i*FIELD_W +: FIELD_W];
      if (idx_2_q == IDX_W'(i)) ext_2 = bus.in_phv[i*FIELD_W +: FIELD_W];
    end
  end

  always_comb begin
    occ_d     = occ_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    idx_1_d   = idx_1_q;
    idx_2_d   = idx_2_q;
    cfg_err_d = cfg_err_q;
    phv_d     = phv_q;
    p1_d      = p1_q;
    p2_d      = p2_q;

    if (push) begin
      phv_d[wr_ptr_q] = bus.in_phv;
      p1_d[wr_ptr_q]  = ext_1;
      p2_d[wr_ptr_q]  = ext_2;
      wr_ptr_d        = ~wr_ptr_q;
      if (bad_1 || bad_2) cfg_err_d = 1'b1;
    end

    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (cfg_wr_en) begin
      idx_1_d = cfg_idx_1;
      idx_2_d = cfg_idx_2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      idx_1_q   <= IDX_W'(0);
      idx_2_q   <= IDX_W'(1);
      cfg_err_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        phv_q[i] <= '0;
        p1_q[i]  <= '0;
        p2_q[i]  <= '0;
      end
    end else begin
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      idx_1_q   <= idx_1_d;
      idx_2_q   <= idx_2_d;
      cfg_err_q <= cfg_err_d;
      phv_q     <= phv_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
    end
  end

  // When empty, the slot behind rd_ptr still holds the last popped entry
  // (nothing is written while empty until a push makes the FIFO valid again).
  assign head_sel = out_valid ? rd_ptr_q : ~rd_ptr_q;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_pkt_1 = p1_q[head_sel];
  assign bus.out_pkt_2 = p2_q[head_sel];
  assign bus.out_phv   = phv_q[head_sel];
  assign cfg_err       = cfg_err_q;

`ifdef PAIR_OPERAND_PERF_EN
  logic [31:0] perf_accepted_q, perf_accepted_d;
  logic [31:0] perf_stalled_q, perf_stalled_d;

  always_comb begin
    perf_accepted_d = perf_accepted_q;
    perf_stalled_d  = perf_stalled_q;
    if (push) perf_accepted_d = perf_accepted_q + 32'd1;
    if (bus.in_valid && !in_ready) perf_stalled_d = perf_stalled_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_accepted_q <= 32'd0;
      perf_stalled_q  <= 32'd0;
    end else begin
      perf_accepted_q <= perf_accepted_d;
      perf_stalled_q  <= perf_stalled_d;
    end
  end

  assign perf_accepted = perf_accepted_q;
  assign perf_stalled  = perf_stalled_q;
`endif

endmodule

// File: tb/tb_pair_operand_stage.sv
// Scoreboard bench for pair_operand_stage: driver queues expected operand pairs, monitor checks each pop.
module tb_pair_operand_stage;
  localparam int NF = 6;
  localparam int FW = 32;
  localparam int IW = 3;
  localparam int W  = NF * FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr_en;
  logic [IW-1:0] cfg_idx_1;
  logic [IW-1:0] cfg_idx_2;
  logic          cfg_err;
`ifdef PAIR_OPERAND_PERF_EN
  logic [31:0]   perf_accepted;
  logic [31:0]   perf_stalled;
`endif

  always #5 clk = ~clk;

  pair_operand_stage_if #(.NUM_FIELDS(NF), .FIELD_W(FW)) bus ();

  pair_operand_stage #(.NUM_FIELDS(NF), .FIELD_W(FW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cfg_wr_en (cfg_wr_en),
    .cfg_idx_1 (cfg_idx_1),
    .cfg_idx_2 (cfg_idx_2),
    .cfg_err   (cfg_err)
`ifdef PAIR_OPERAND_PERF_EN
    ,
    .perf_accepted (perf_accepted),
    .perf_stalled  (perf_stalled)
`endif
  );

  typedef struct {
    logic [FW-1:0] p1;
    logic [FW-1:0] p2;
    logic [W-1:0]  phv;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   n_acc = 0;
  int   n_stall = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int base);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NF; i++) v[i*FW +: FW] = FW'(base + i);
    return v;
  endfunction

  // Monitor: compares the head against the scoreboard on every pop and
  // checks the outputs stayed put across stalled cycles.
  logic          stall_prev = 1'b0;
  logic [FW-1:0] prev_1, prev_2;
  logic [W-1:0]  prev_phv;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.in_valid && !bus.in_ready) n_stall++;
      if (bus.out_valid && stall_prev) begin
        check("hold_pkt_1", bus.out_pkt_1, prev_1);
        check("hold_pkt_2", bus.out_pkt_2, prev_2);
        check("hold_phv", bus.out_phv, prev_phv);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: pkt_1=0x%0h with empty scoreboard", bus.out_pkt_1);
        end else begin
          e = exp_q.pop_front();
          check("out_pkt_1", bus.out_pkt_1, e.p1);
          check("out_pkt_2", bus.out_pkt_2, e.p2);
          check("out_phv", bus.out_phv, e.phv);
          n_out++;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_1     = bus.out_pkt_1;
      prev_2     = bus.out_pkt_2;
      prev_phv   = bus.out_phv;
    end
  end

  // Present one PHV until accepted; the expected operands enter the scoreboard at acceptance.
  task automatic send(input logic [W-1:0] phv, input logic [FW-1:0] e1, input logic [FW-1:0] e2);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_phv   = phv;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc   = 1'b1;
        e.p1  = e1;
        e.p2  = e2;
        e.phv = phv;
        exp_q.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    cfg_wr_en    = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 20 cycles, need 1");
    end
  endtask

  task automatic cfg(input logic [IW-1:0] a, input logic [IW-1:0] b);
    cfg_wr_en = 1'b1;
    cfg_idx_1 = a;
    cfg_idx_2 = b;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_phv    = '0;
    bus.out_ready = 1'b0;
    cfg_wr_en     = 1'b0;
    cfg_idx_1     = '0;
    cfg_idx_2     = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_pkt_1", bus.out_pkt_1, 0);
    check("rst_pkt_2", bus.out_pkt_2, 0);
    check("rst_phv", bus.out_phv, 0);
    check("rst_cfg_err", cfg_err, 0);
`ifdef PAIR_OPERAND_PERF_EN
    check("rst_perf_acc", perf_accepted, 0);
    check("rst_perf_stall", perf_stalled, 0);
`endif
    @(posedge clk);
    #1;

    // Single packet with default indices 0/1
    bus.out_ready = 1'b1;
    send(mk(10), 32'd10, 32'd11);
    check("t1_out_valid", bus.out_valid, 1);
    idle(1);
    check("t1_drained", bus.out_valid, 0);
    check("t1_hold_pkt_1", bus.out_pkt_1, 32'd10);
    check("t1_hold_pkt_2", bus.out_pkt_2, 32'd11);

    // Config written on A's accept edge applies from B onward
    cfg_wr_en = 1'b1;
    cfg_idx_1 = 3'd5;
    cfg_idx_2 = 3'd2;
    send(mk(10), 32'd10, 32'd11);
    send(mk(10), 32'd15, 32'd12);
    idle(3);

    // Fill with out_ready=0, third PHV waits
    bus.out_ready = 1'b0;
    send(mk(30), 32'd35, 32'd32);
    check("t3_in_ready_occ1", bus.in_ready, 1);
    send(mk(40), 32'd45, 32'd42);
    check("t3_in_ready_full", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_phv   = mk(50);
    repeat (3) begin
      @(negedge clk);
      check("t3_in_ready_stall", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(mk(50), 32'd55, 32'd52);
    idle(4);
    check("t3_out_count", n_out, 6);

    // Occupancy-1 streaming: push and pop every cycle
    cfg(3'd1, 3'd3);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) check("t4_in_ready", bus.in_ready, 1);
      send(mk(100 + i*10), FW'(101 + i*10), FW'(103 + i*10));
      check("t4_out_valid", bus.out_valid, 1);
    end
    idle(3);
    check("t4_out_count", n_out, 26);
    check("t4_no_leftover", exp_q.size(), 0);

    // Out-of-range index extracts zero and sets the sticky error
    cfg_wr_en = 1'b1;
    cfg_idx_1 = 3'd7;
    cfg_idx_2 = 3'd0;
    send(mk(300), 32'd301, 32'd303);
    check("t5_err_before", cfg_err, 0);
    send(mk(400), 32'd0, 32'd400);
    check("t5_err_set", cfg_err, 1);
    idle(10);
    check("t5_err_sticky", cfg_err, 1);
`ifdef PAIR_OPERAND_PERF_EN
    check("perf_accepted", perf_accepted, n_acc);
    check("perf_stalled", perf_stalled, n_stall);
`endif

    // Asynchronous reset with two entries buffered
    bus.out_ready = 1'b0;
    send(mk(500), 32'd0, 32'd500);
    send(mk(600), 32'd0, 32'd600);
    check("t6_full", bus.in_ready, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_valid", bus.out_valid, 0);
    check("t6_async_ready", bus.in_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("t6_cfg_err", cfg_err, 0);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_pkt_1", bus.out_pkt_1, 0);
    check("t6_phv", bus.out_phv, 0);
`ifdef PAIR_OPERAND_PERF_EN
    check("t6_perf_acc", perf_accepted, 0);
    check("t6_perf_stall", perf_stalled, 0);
`endif
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(mk(700), 32'd700, 32'd701);
    idle(3);
    check("t6_no_leftover", exp_q.size(), 0);
    check("t6_out_count", n_out, 29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pair_operand_stage.md
Name: pair_operand_stage

Overview:
- Upstream feeder for the two-state stateful ALU atom (pkt_1/pkt_2 operands, paired state_1/state_2).
- Accepts packet header vectors (PHV) over a valid/ready handshake.
- Extracts two configurable fields and buffers them in a 2-entry FIFO.
- Presents them to the atom as out_pkt_1/out_pkt_2, with out_valid used by the atom stage as its state-update enable. The full PHV passes through alongside for downstream writeback.

Parameters:
- NUM_FIELDS, 8, number of 32-bit PHV containers.
- FIELD_W, 32, container width; must match the atom's int32 operands.
- IDX_W, 3, field-index width; must be ≥ clog2(NUM_FIELDS).

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream PHV valid
- in_ready  out  1  stage can accept a PHV this cycle
- in_phv  in  NUM_FIELDS*FIELD_W  field i at bits [i*FIELD_W +: FIELD_W]
- cfg_wr_en  in  1  load new field indices
- cfg_idx_1  in  IDX_W  field index routed to out_pkt_1
- cfg_idx_2  in  IDX_W  field index routed to out_pkt_2
- cfg_err  out  1  sticky: a packet was extracted with an out-of-range index
- out_valid  out  1  head entry valid; atom state-update enable
- out_ready  in  1  atom stage consumes head this cycle
- out_pkt_1  out  FIELD_W  extracted operand 1
- out_pkt_2  out  FIELD_W  extracted operand 2
- out_phv  out  NUM_FIELDS*FIELD_W  pass-through PHV of head entry

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: occupancy 0; out_valid 0; out_pkt_1, out_pkt_2 and out_phv 0; active indices idx_1=0, idx_2=1; cfg_err 0. in_ready is 1 on the first cycle after reset release.
- Reset asserted mid-operation discards all buffered entries immediately, with no drain.
- Accept: a transfer happens when in_valid && in_ready on a rising clk edge.
  - At acceptance the stage captures in_phv and the fields at the active idx_1 and idx_2 into the tail entry.
  - Extraction uses the indices active before any same-cycle cfg write.
- Config:
  - cfg_wr_en on an edge loads cfg_idx_1/cfg_idx_2 into the active indices.
  - New indices apply to packets accepted from the next cycle onward.
  - Packets already buffered are not re-extracted.
- Index range: an index ≥ NUM_FIELDS extracts value 0 for that operand and sets cfg_err on the accepting edge. cfg_err clears only on reset.
- FIFO: depth 2, head drives the outputs.
  - out_valid = (occupancy != 0).
  - in_ready = (occupancy != 2); this is decoded from registered occupancy only, with no combinational path from out_ready.
  - Latency: a PHV accepted at edge t is visible on the outputs after edge t when the FIFO was empty. Otherwise it becomes visible after the pops of older entries.
- Pop: out_valid && out_ready on an edge removes the head. The next entry becomes head after the same edge.
- Simultaneous push and pop:
  - occupancy 1: occupancy stays 1, new entry becomes head.
  - occupancy 2: no push possible (in_ready=0); pop only.
  - occupancy 0: push only (no valid head to pop).
- Output holding:
  - While out_valid=1 && out_ready=0, out_pkt_1, out_pkt_2 and out_phv are stable.
  - While out_valid=0, the outputs hold the last popped values.
- Data is stored unmodified, with no arithmetic. Read and write pointers are 1 bit each and wrap 1→0.

Optional Feature:
- Macro: PAIR_OPERAND_PERF_EN.
- Defined:
  - Adds outputs perf_accepted (32b) and perf_stalled (32b), both reset to 0.
  - perf_accepted increments on each accept.
  - perf_stalled increments each cycle with in_valid && !in_ready.
  - Both wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push PHV fields {0..7} = {10,11,...,17} with out_ready=1 → next cycle out_valid=1, out_pkt_1=10, out_pkt_2=11; popped at the following edge, out_valid=0.
- cfg_wr_en with idx_1=5, idx_2=2 on the same edge as accepting PHV A, then PHV B next cycle → A yields (10,11), B yields fields 5 and 2 (15,12).
- Hold out_ready=0, push 3 PHVs back-to-back → first two accepted, in_ready=0 from the cycle after the second accept, third held. Raise out_ready → entries popped in order with stable data while stalled; third accepted once occupancy drops.
- cfg_idx_1=7, cfg_idx_2=0 with NUM_FIELDS=6 → out_pkt_1=0, out_pkt_2=field 0, cfg_err=1 and still 1 after 10 idle cycles.
- Occupancy 1 with simultaneous push and pop for 20 cycles → in_ready stays 1, one packet out per cycle, zero drops and no reordering.
- Assert rst_n low asynchronously mid-cycle with 2 entries buffered → out_valid drops immediately; after release, cfg indices are 0/1 and occupancy is 0. With PAIR_OPERAND_PERF_EN defined, counters read 0.
